// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port SRAM arbiter.
package sram_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Who owns the response returning from the SRAM next cycle
   typedef enum logic [1:0] {
      NONE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2
   } owner_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant selector: fixed data priority, or round-robin on
// contention when SRAM_ARB_RR_EN is defined.
module sram_arb_grant
   import sram_arb_pkg::*;
(
   input  logic   inst_req,
   input  logic   data_req,
   input  owner_e last_grant,
   output owner_e grant
);

`ifdef SRAM_ARB_RR_EN
   always_comb begin
      grant = NONE;
      if (inst_req && data_req) begin
         // Contention goes to whichever side lost the previous grant
         grant = (last_grant == DATA) ? INST : DATA;
      end else if (data_req) begin
         grant = DATA;
      end else if (inst_req) begin
         grant = INST;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   always_comb begin
      grant = NONE;
      if (data_req) begin
         grant = DATA;
      end else if (inst_req) begin
         grant = INST;
      end
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between fetch and data requesters.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration on contention.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   input  logic                inst_cancel,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                sram_en,
   output logic [DATA_W/8-1:0] sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int STRB_W = DATA_W / 8;

   owner_e              pend_reg, pend_next;
   logic                drop_reg, drop_next;
   logic                ready_reg;
   owner_e              last_grant;
   owner_e              grant;
   logic                inst_req_gated;
   logic                data_req_gated;
   logic [STRB_W-1:0]   data_we;

   // Hold off grants while in reset and for the first cycle after it
   assign inst_req_gated = inst_req & resetn & ready_reg;
   assign data_req_gated = data_req & resetn & ready_reg;

   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_we
      assign data_we[gi] = data_wr & data_wstrb[gi];
   end

   sram_arb_grant u_grant (
      .inst_req   (inst_req_gated),
      .data_req   (data_req_gated),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef SRAM_ARB_RR_EN
   owner_e last_grant_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant_reg <= INST;
      end else if (grant != NONE) begin
         last_grant_reg <= grant;
      end
   end

   assign last_grant = last_grant_reg;
`else
   assign last_grant = INST;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pend_reg  <= NONE;
         drop_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         pend_reg  <= pend_next;
         drop_reg  <= drop_next;
         ready_reg <= 1'b1;
      end
   end

   always_comb begin
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      sram_en      = 1'b0;
      sram_we      = '0;
      sram_addr    = '0;
      sram_wdata   = '0;
      pend_next    = grant;
      drop_next    = inst_cancel && (grant == INST);

      case (grant)
         INST: begin
            inst_addr_ok = 1'b1;
            sram_en      = 1'b1;
            sram_addr    = inst_addr;
         end
         DATA: begin
            data_addr_ok = 1'b1;
            sram_en      = 1'b1;
            sram_we      = data_we;
            sram_addr    = data_addr;
            sram_wdata   = data_wdata;
         end
         default: ;
      endcase

      // A late cancel suppresses the fetch response landing this cycle
      if (resetn) begin
         if (pend_reg == INST && !drop_reg && !inst_cancel) begin
            inst_data_ok = 1'b1;
            inst_rdata   = sram_rdata;
         end else if (pend_reg == DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = sram_rdata;
         end
      end
   end

endmodule
